// File: rtl/sa_output_deskew.sv
// Realigns the skewed bottom-row outputs of the systolic array into full rows and buffers them in a FWFT FIFO.
// Optional macro SA_DESKEW_RELU_EN clamps negative lanes to zero before the FIFO write.
module sa_output_deskew #(
  parameter int D_W        = 8,
  parameter int N          = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          I_CLK,
  input  logic                          I_SYNC_RST,
  input  logic                          I_FLUSH,
  input  logic [N*D_W-1:0]              I_D_VEC,
  input  logic                          I_VLD_COL0,
  output logic [N*D_W-1:0]              O_DATA,
  output logic                          O_VLD,
  input  logic                          I_RDY,
  output logic [$clog2(FIFO_DEPTH):0]   O_CNT,
  output logic                          O_FULL,
  output logic                          O_OVF
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [N*D_W-1:0] w_aln;
  logic [N*D_W-1:0] w_wr_data;
  logic             w_wr_vld;
  logic             w_pop;
  logic             w_full;
  logic             w_wr;
  logic             w_ovf;

  logic [N-2:0]     r_vld_p;
  logic [N*D_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;

  // Deskew stage: lane j is delayed by N-1-j cycles so every lane of a row lines up with lane N-1.
  for (genvar gj = 0; gj < N; gj++) begin : g_lane
    if (gj == N - 1) begin : g_pass
      assign w_aln[gj*D_W +: D_W] = I_D_VEC[gj*D_W +: D_W];
    end else begin : g_dly
      localparam int L = N - 1 - gj;
      logic signed [D_W-1:0] r_sh_p [L];
      always_ff @(posedge I_CLK) begin
        if (I_SYNC_RST) begin
          for (int s = 0; s < L; s++) r_sh_p[s] <= '0;
        end else begin
          r_sh_p[0] <= I_D_VEC[gj*D_W +: D_W];
          for (int s = 1; s < L; s++) r_sh_p[s] <= r_sh_p[s-1];
        end
      end
      assign w_aln[gj*D_W +: D_W] = r_sh_p[L-1];
    end
  end

  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST || I_FLUSH) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= I_VLD_COL0;
      for (int s = 1; s < N - 1; s++) r_vld_p[s] <= r_vld_p[s-1];
    end
  end

  assign w_wr_vld = r_vld_p[N-2];

`ifdef SA_DESKEW_RELU_EN
  function automatic logic [N*D_W-1:0] relu_row(input logic [N*D_W-1:0] row);
    logic signed [D_W-1:0] lane;
    relu_row = '0;
    for (int j = 0; j < N; j++) begin
      lane = row[j*D_W +: D_W];
      relu_row[j*D_W +: D_W] = lane[D_W-1] ? '0 : lane;
    end
  endfunction

  assign w_wr_data = relu_row(w_aln);
`else
  assign w_wr_data = w_aln;
`endif

  // FIFO stage: a pop frees a slot in the same cycle, so a full FIFO still accepts a row when popped.
  assign O_VLD  = (r_cnt != '0);
  assign w_full = (r_cnt == DEPTH_C);
  assign w_pop  = O_VLD & I_RDY;
  assign w_wr   = w_wr_vld & (~w_full | w_pop);
  assign w_ovf  = w_wr_vld & w_full & ~w_pop;

  always_ff @(posedge I_CLK) begin
    if (I_SYNC_RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (I_FLUSH) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= w_wr_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_wr && w_pop) r_cnt <= r_cnt - 1'b1;
      if (w_ovf) r_ovf <= 1'b1;
    end
  end

  assign O_DATA = r_mem[r_rd_ptr];
  assign O_CNT  = r_cnt;
  assign O_FULL = w_full;
  assign O_OVF  = r_ovf;

endmodule

// File: doc/sa_output_deskew.md
Name: sa_output_deskew

Overview:
- Sits directly below the bottom row of the N-column systolic PE array.
- Consumes each column's O_D output; column j's element of a result row emerges j cycles after column 0's element.
- Realigns the skewed columns into one full-width row and buffers rows in a small FIFO.
- Presents rows downstream through a valid/ready handshake. The array cannot be stalled, so FIFO overflow is flagged, not back-pressured.

Parameters:
- D_W, 8, element width (signed two's complement, same format as PE O_D).
- N, 4, number of array columns (lanes); N >= 2.
- FIFO_DEPTH, 4, row capacity of output FIFO; power of 2, >= 2.

Ports:
- I_CLK  in  1  clock, all logic on rising edge.
- I_SYNC_RST  in  1  reset, synchronous, active-high.
- I_FLUSH  in  1  synchronous flush of deskew valids, FIFO and overflow flag.
- I_D_VEC  in  N*D_W  bottom-row O_D of column j at bits [j*D_W +: D_W].
- I_VLD_COL0  in  1  high in the cycle column 0's element of a result row is on I_D_VEC lane 0.
- O_DATA  out  N*D_W  aligned row at FIFO head, lane packing as I_D_VEC.
- O_VLD  out  1  FIFO non-empty; O_DATA valid.
- I_RDY  in  1  downstream accepts; pop when O_VLD & I_RDY.
- O_CNT  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy in rows.
- O_FULL  out  1  O_CNT == FIFO_DEPTH.
- O_OVF  out  1  sticky: an aligned row was dropped.

Behaviour:
- Reset: I_SYNC_RST high at an edge clears all state. O_VLD=0, O_CNT=0, O_FULL=0, O_OVF=0, O_DATA=0, deskew data/valid regs=0. Reset mid-stream discards all partial and buffered rows.
- Deskew data path: lane j passes through (N-1-j) registers, so lane N-1 has no register and lane 0 has N-1. All lanes of one row are co-present in the same cycle.
- Deskew valid path: I_VLD_COL0 is delayed through an (N-1)-stage shift register. Its output, wr_vld, is the aligned-row valid.
- Deskew registers shift every cycle unconditionally; the array is free-running.
- Latency: I_VLD_COL0=1 at cycle t (lane j data at cycle t+j). The row is written at the edge ending cycle t+N-1 and appears on O_DATA with O_VLD=1 in cycle t+N (empty FIFO case). There is no combinational bypass.
- FIFO: first-word-fall-through, registered storage, binary pointers wrap modulo FIFO_DEPTH; O_DATA = mem[rd_ptr].
- Write occurs when wr_vld & (!full | pop).
  - Full with simultaneous pop: the write is accepted, O_CNT stays FIFO_DEPTH, no overflow.
- Overflow: wr_vld & full & !pop drops the incoming row and sets O_OVF=1 until reset or flush. FIFO contents are unchanged.
- Empty: O_VLD=0; I_RDY is ignored; no pointer change.
- Occupancy: O_CNT +1 on write only, -1 on pop only, unchanged on both or neither.
- Back-to-back rows (I_VLD_COL0 high on consecutive cycles) produce one write per cycle. Full throughput is 1 row/cycle.
- Flush: I_FLUSH=1 at an edge clears pointers, O_CNT, O_OVF and the valid shift register. Data regs need not clear. Flush has priority over a coincident write and pop; in-flight partial rows are lost.
- Arithmetic: none on the data path apart from the optional feature; widths pass through unchanged.

Optional Feature:
- Macro SA_DESKEW_RELU_EN.
- Defined: each aligned lane is clamped to 0 before the FIFO write if its sign bit (MSB) is 1; non-negative values pass unchanged. Latency is unchanged; the clamp is combinational between the deskew and FIFO write.
- Undefined: lanes are written verbatim; no clamp logic is present.

Test Plan (N=4, D_W=8, FIFO_DEPTH=4):
- Single row: I_VLD_COL0=1 at cycle 10; lane j = 8'h11*(j+1) driven at cycle 10+j -> O_VLD=1 at cycle 14, O_DATA=32'h44332211, O_CNT=1; pop at cycle 14 -> O_VLD=0 at cycle 15.
- Streaming: 8 consecutive rows (lane0 value k=0..7, other lanes skewed accordingly), I_RDY=1 throughout -> 8 consecutive O_VLD cycles in order, O_CNT never exceeds 1, O_OVF=0.
- Overflow: I_RDY=0, 5 rows in -> O_FULL=1 after 4th write, O_OVF=1 after 5th. Draining yields rows 0..3 only, and O_OVF stays 1.
- Full with pop: FIFO full, row arrives while O_VLD&I_RDY -> write accepted, O_CNT stays 4, O_OVF=0, next head is row 1.
- Flush/reset mid-operation: 2 rows buffered plus 1 in deskew, pulse I_FLUSH -> O_VLD=0, O_CNT=0, O_OVF=0 next cycle, and no late row emerges. Repeating with I_SYNC_RST gives identical result.
- ReLU (macro defined): row lanes 8'hF0,8'h05,8'h80,8'h7F -> O_DATA lanes 00,05,00,7F. With macro undefined -> F0,05,80,7F.
